arbitrage_detector: RTL
=======================

// Module: arbitrage_detector
// PURPOSE
//  Sits directly downstream of the UART packet parser. Consumes each validated price pair (price_A, price_B, packet_valid pulse).
//  Computes the cross-exchange spread; when spread >= MIN_SPREAD, issues one trade request (buy cheap side, sell dear side) over a valid/ready handshake.
//  Enforces a post-trade cooldown and keeps saturating opportunity and dropped-update counters for the status/LED logic.
// PARAMETERS
//  PRICE_W       16    width of price inputs and trade price/spread outputs
//  MIN_SPREAD    5     minimum unsigned spread (price units) that triggers a trade
//  COOLDOWN_CYC  1000  cycles spent in COOLDOWN after each accepted trade; 0 = no cooldown
//  CNT_W         16    width of opp_count / drop_count
// PORTS
//  clk               in   1        50 MHz system clock; all logic on posedge
//  rst               in   1        synchronous reset, active-high
//  price_A           in   PRICE_W  exchange A price from parser; valid only when packet_valid=1
//  price_B           in   PRICE_W  exchange B price from parser; valid only when packet_valid=1
//  packet_valid      in   1        1-cycle pulse: new price pair present
//  trade_valid       out  1        trade request pending
//  trade_ready       in   1        downstream order sender accepts request
//  trade_dir         out  1        0 = buy A / sell B (A cheaper); 1 = buy B / sell A
//  trade_buy_price   out  PRICE_W  lower of the two latched prices
//  trade_sell_price  out  PRICE_W  higher of the two latched prices
//  trade_spread      out  PRICE_W  trade_sell_price - trade_buy_price
//  opp_count         out  CNT_W    number of trades issued (saturating)
//  drop_count        out  CNT_W    packet_valid pulses ignored while busy (saturating)
//  busy              out  1        1 whenever state != IDLE
// BEHAVIOUR
//  Reset (rst=1 at a posedge): state=IDLE; trade_valid=0; all trade_* outputs=0; opp_count=0; drop_count=0; busy=0; cooldown counter=0.
//   Reset overrides everything, including mid-handshake and mid-cooldown; a pending trade is discarded and never counted as accepted.
//  FSM states: IDLE, COMPARE, ISSUE, COOLDOWN.
//  IDLE: on packet_valid, latch price_A/price_B into internal regs and go to COMPARE. Otherwise stay in IDLE.
//  COMPARE (exactly 1 cycle), unsigned compare:
//   - A < B: dir=0, buy=A, sell=B, spread=B-A.
//   - B < A: dir=1, buy=B, sell=A, spread=A-B.
//   - A == B: spread=0 (no trade).
//   - spread >= MIN_SPREAD: register trade_* outputs, set trade_valid=1, opp_count+=1 (hold at all-ones), go to ISSUE.
//   - else: go to IDLE; trade_* outputs unchanged.
//   - Subtraction is always larger-minus-smaller, so it never underflows; no sign bit is needed.
//  Latency: packet_valid high in cycle N -> trade_valid first high in cycle N+2.
//  ISSUE: trade_valid=1 and all trade_* outputs held stable until a cycle with trade_valid & trade_ready.
//   On that handshake cycle: trade_valid=0 from the next cycle.
//   Next state is COOLDOWN (COOLDOWN_CYC>0) or IDLE (COOLDOWN_CYC=0).
//   trade_ready may be high before trade_valid; the handshake completes in the first ISSUE cycle.
//  COOLDOWN: counter loads COOLDOWN_CYC-1 on entry, decrements each cycle, goes to IDLE when it reaches 0.
//   The FSM therefore spends exactly COOLDOWN_CYC cycles in COOLDOWN.
//  Drops: packet_valid in COMPARE, ISSUE or COOLDOWN is ignored (no latch, no effect on outputs); drop_count+=1, saturating at all-ones.
//  Simultaneous: a packet_valid in the same cycle the FSM leaves COOLDOWN for IDLE counts as a drop.
//   A packet_valid in the first IDLE cycle is accepted.
//  trade_* outputs retain the last trade's values after the handshake (informational only; qualified by trade_valid).
// TESTING
//  1. A=1000, B=1010, packet_valid at cycle N -> trade_valid at N+2; dir=0, buy=1000, sell=1010, spread=10; opp_count=1.
//  2. A=2000, B=2003 (spread 3 < 5) -> trade_valid never asserts; FSM returns to IDLE at N+2; opp_count unchanged.
//     A=B=500 -> same result.
//  3. A=0xFFFF, B=0x0000 -> dir=1, buy=0, sell=0xFFFF, spread=0xFFFF (no wrap).
//  4. trade_ready held low 20 cycles after trade_valid -> outputs stable for all 20 cycles; ready=1 -> 1-cycle handshake;
//     then busy stays high COOLDOWN_CYC cycles; 3 packet_valid pulses during cooldown -> drop_count=3, no new trade.
//  5. rst=1 while in ISSUE (trade_valid=1, ready=0) -> next cycle trade_valid=0, busy=0, counters=0;
//     a subsequent valid pair trades normally.
//  6. Force opp_count/drop_count to all-ones (CNT_W=4 build, 20 events) -> both hold at 15, no wrap.

Source files
------------

// File: rtl/arbitrage_detector.sv
// Cross-exchange arbitrage detector: latches a validated price pair, issues one
// trade request over valid/ready when the spread is wide enough, then cools down.
module arbitrage_detector #(
    parameter int unsigned PRICE_W      = 16,
    parameter int unsigned MIN_SPREAD   = 5,
    parameter int unsigned COOLDOWN_CYC = 1000,
    parameter int unsigned CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PRICE_W-1:0] price_A,
    input  logic [PRICE_W-1:0] price_B,
    input  logic               packet_valid,
    output logic               trade_valid,
    input  logic               trade_ready,
    output logic               trade_dir,
    output logic [PRICE_W-1:0] trade_buy_price,
    output logic [PRICE_W-1:0] trade_sell_price,
    output logic [PRICE_W-1:0] trade_spread,
    output logic [CNT_W-1:0]   opp_count,
    output logic [CNT_W-1:0]   drop_count,
    output logic               busy
);

    // The cooldown counter only ever holds COOLDOWN_CYC-1 down to 0.
    localparam int unsigned CD_W = (COOLDOWN_CYC > 2) ? $clog2(COOLDOWN_CYC) : 1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_COMPARE  = 2'd1;
    localparam logic [1:0] S_ISSUE    = 2'd2;
    localparam logic [1:0] S_COOLDOWN = 2'd3;

    logic [1:0]         state;
    logic [PRICE_W-1:0] lat_a;
    logic [PRICE_W-1:0] lat_b;
    logic [CD_W-1:0]    cd_cnt;

    logic               cmp_dir;
    logic [PRICE_W-1:0] cmp_buy;
    logic [PRICE_W-1:0] cmp_sell;
    logic [PRICE_W-1:0] cmp_spread;
    logic               cmp_hit;

    always_comb begin
        // NOTE: every always_comb output is given a default first so no path can infer a latch.
        cmp_dir  = 1'b0;
        cmp_buy  = lat_a;
        cmp_sell = lat_b;
        if (lat_b < lat_a) begin
            cmp_dir  = 1'b1;
            cmp_buy  = lat_b;
            cmp_sell = lat_a;
        end
        cmp_spread = cmp_sell - cmp_buy;
        cmp_hit    = (lat_a != lat_b) && (cmp_spread >= PRICE_W'(MIN_SPREAD));
    end

    assign busy = (state != S_IDLE);

    // NOTE: registers use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            lat_a            <= '0;
            lat_b            <= '0;
            cd_cnt           <= '0;
            trade_valid      <= 1'b0;
            trade_dir        <= 1'b0;
            trade_buy_price  <= '0;
            trade_sell_price <= '0;
            trade_spread     <= '0;
            opp_count        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (packet_valid) begin
                        lat_a <= price_A;
                        lat_b <= price_B;
                        state <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (cmp_hit) begin
                        trade_dir        <= cmp_dir;
                        trade_buy_price  <= cmp_buy;
                        trade_sell_price <= cmp_sell;
                        trade_spread     <= cmp_spread;
                        trade_valid      <= 1'b1;
                        if (opp_count != '1)
                            opp_count <= opp_count + 1'b1;
                        state <= S_ISSUE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (trade_ready) begin
                        trade_valid <= 1'b0;
                        if (COOLDOWN_CYC == 0) begin
                            state <= S_IDLE;
                        end else begin
                            cd_cnt <= CD_W'(COOLDOWN_CYC - 1);
                            state  <= S_COOLDOWN;
                        end
                    end
                end
                S_COOLDOWN: begin
                    if (cd_cnt == '0)
                        state <= S_IDLE;
                    else
                        cd_cnt <= cd_cnt - 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Any pulse arriving outside IDLE, including the cycle that leaves COOLDOWN, is a drop.
    always_ff @(posedge clk) begin
        if (rst)
            drop_count <= '0;
        else if (packet_valid && (state != S_IDLE) && (drop_count != '1))
            drop_count <= drop_count + 1'b1;
    end

endmodule
